// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encodings and the default operand width.
package seq_mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/add_nbit.sv
// Combinational ripple-carry adder built from half/full-adder cells; used as
// the partial-sum adder of seq_mult.
module add_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .sum  (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

endmodule

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// Full adder as two chained half adders; the two carries can never both be set.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1, c1, c2;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (s1),
    .cout (c1)
  );

  half_adder u_ha1 (
    .a    (s1),
    .b    (cin),
    .sum  (sum),
    .cout (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH
// iterations per operation, unsigned or two's-complement operands.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   product_reg;
  logic                 neg_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     psum;
  logic                 pcout;
  logic                 last_iter;
  logic                 neg_in;

  // Magnitudes are taken as unsigned WIDTH-bit values, so -2^(WIDTH-1) maps
  // to 2^(WIDTH-1) without overflow.
  assign a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

  assign addend = acc_reg[0] ? mcand_reg : '0;

  add_nbit #(.WIDTH(WIDTH)) u_add (
    .a    (acc_reg[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (psum),
    .cout (pcout)
  );

  // The adder carry becomes the new MSB as the accumulator shifts right.
  assign acc_next  = {pcout, psum, acc_reg[WIDTH-1:1]};
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      neg_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mcand_reg <= a_mag;
            acc_reg   <= {{WIDTH{1'b0}}, b_mag};
            neg_reg   <= neg_in;
            cnt_reg   <= '0;
          end
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_iter) begin
            product_reg <= neg_reg ? -acc_next : acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = product_reg;
  assign busy    = (state_reg == ST_RUN) || (state_reg == ST_DONE);
  assign done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult at WIDTH=8: reset, unsigned/signed products,
// latency, handshake corner cases and a short random sweep.
module tb_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           is_signed = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .product   (product),
    .busy      (busy),
    .done      (done)
  );

  // Runs one operation from an IDLE cycle; optionally pulses start (with
  // other operands) in cycle 'inject' of the run. Returns in the next IDLE cycle.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic is, input int inject,
                       output logic [2*W-1:0] p, output int lat,
                       output bit busy_ok);
    int cyc;
    a = ia; b = ib; is_signed = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ia; b = ib + 8'd1; is_signed = ~is;
    busy_ok = 1'b1; cyc = 1; lat = -1;
    while (cyc <= 20) begin
      if (cyc == inject) begin
        start = 1'b1; a = 8'd2; b = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    p = product;
    $display("op a=%02h b=%02h signed=%0d product=%04h latency=%0d", ia, ib, is, p, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h want=0000", product); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_release busy=%b done=%b want 0 0", busy, done); end
    $display("reset released");
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] p; int lat; bit bok;
    do_op(8'd13, 8'd11, 1'b0, 0, p, lat, bok);
    total++; if (p !== 16'd143) begin bad++; $display("FAIL u_13x11 got=%0d want=143", p); end
    total++; if (lat != 9) begin bad++; $display("FAIL u_latency got=%0d want=9", lat); end
    total++; if (!bok) begin bad++; $display("FAIL u_busy got=low want=high in cycles 1..9"); end
    do_op(8'd255, 8'd255, 1'b0, 0, p, lat, bok);
    total++; if (p !== 16'hFE01) begin bad++; $display("FAIL u_255x255 got=%h want=fe01", p); end
    do_op(8'd0, 8'd200, 1'b0, 0, p, lat, bok);
    total++; if (p !== 16'h0000) begin bad++; $display("FAIL u_0x200 got=%h want=0000", p); end
  endtask

  task automatic test_signed();
    logic [2*W-1:0] p; int lat; bit bok;
    do_op(8'hFD, 8'd5, 1'b1, 0, p, lat, bok);
    total++; if (p !== 16'hFFF1) begin bad++; $display("FAIL s_m3x5 got=%h want=fff1", p); end
    do_op(8'h80, 8'h80, 1'b1, 0, p, lat, bok);
    total++; if (p !== 16'h4000) begin bad++; $display("FAIL s_m128xm128 got=%h want=4000", p); end
    do_op(8'h80, 8'h7F, 1'b1, 0, p, lat, bok);
    total++; if (p !== 16'hC080) begin bad++; $display("FAIL s_m128x127 got=%h want=c080", p); end
    total++; if (lat != 9) begin bad++; $display("FAIL s_latency got=%0d want=9", lat); end
  endtask

  task automatic test_ignore_start();
    logic [2*W-1:0] p; int lat; bit bok;
    do_op(8'd13, 8'd11, 1'b0, 4, p, lat, bok);
    total++; if (p !== 16'd143) begin bad++; $display("FAIL busy_start_product got=%0d want=143", p); end
    total++; if (lat != 9) begin bad++; $display("FAIL busy_start_latency got=%0d want=9", lat); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    a = 8'd3; b = 8'd4; is_signed = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      exp_done = ((cyc % 10) == 9);
      total++;
      if (done !== exp_done) begin bad++; $display("FAIL b2b_done cycle=%0d got=%b want=%b", cyc, done, exp_done); end
      if (done) begin
        total++;
        if (product !== 16'd12) begin bad++; $display("FAIL b2b_product cycle=%0d got=%0d want=12", cyc, product); end
        $display("op a=03 b=04 signed=0 product=%04h back-to-back cycle=%0d", product, cyc);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [2*W-1:0] p; int lat; bit bok; bit saw_done;
    a = 8'd13; b = 8'd11; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL midrst_product got=%h want=0000", product); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    saw_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL midrst_no_done got=pulse want=none"); end
    $display("reset mid-operation, aborted");
    do_op(8'd7, 8'd9, 1'b0, 0, p, lat, bok);
    total++; if (p !== 16'd63) begin bad++; $display("FAIL midrst_next got=%0d want=63", p); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] p, e; int lat; bit bok;
    logic [W-1:0] ra, rb; logic rs; int ea, eb;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      ea = rs ? int'($signed(ra)) : int'(ra);
      eb = rs ? int'($signed(rb)) : int'(rb);
      e = 16'(ea * eb);
      do_op(ra, rb, rs, 0, p, lat, bok);
      total++;
      if (p !== e || lat != 9) begin
        bad++;
        $display("FAIL random a=%h b=%h s=%0d got=%h lat=%0d want=%h lat=9", ra, rb, rs, p, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
